pht_update_scheduler: RTL

- Sequences all writes into the single-write-port pattern history table (PHT) of the global-history branch predictor.
- After reset, sweeps every entry to the weakly-taken value.
- In normal operation, accepts up to REQ_NUM branch-result counter updates per cycle, merges updates that target the same index, buffers them in a FIFO and drains one write per cycle to the PHT.
- Sits between the integer-execute branch-result ports and the PHT RAM write port.

---
 rtl/pht_update_scheduler_pkg.sv | 32 +++
 rtl/pht_update_scheduler_if.sv | 29 ++
 rtl/pht_update_fifo.sv | 79 +++++++
 rtl/pht_update_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pht_update_scheduler_pkg.sv
// Shared types and counter arithmetic for the PHT update scheduler.
// Index-carrying types are sized to the default table; modules re-derive them from INDEX_WIDTH.
package pht_update_scheduler_pkg;

    localparam int CTR_WIDTH       = 2;
    localparam int DEF_INDEX_WIDTH = 10;

    typedef logic [DEF_INDEX_WIDTH-1:0] PHT_IndexPath;
    typedef logic [CTR_WIDTH-1:0]       PHT_CounterPath;

    typedef struct packed {
        PHT_IndexPath   index;
        PHT_CounterPath value;
    } PhtUpdateEntry;

    localparam PHT_CounterPath CTR_MAX  = '1;
    localparam PHT_CounterPath CTR_INIT = PHT_CounterPath'(1 << (CTR_WIDTH - 1));

    typedef enum logic {
        INIT,
        RUN
    } SchedState;

    // Saturating step toward the resolved direction; never wraps.
    function automatic PHT_CounterPath ctr_next(PHT_CounterPath prev, logic taken);
        if (taken) begin
            return (prev == CTR_MAX) ? CTR_MAX : prev + 1'b1;
        end
        return (prev == '0) ? '0 : prev - 1'b1;
    endfunction

endpackage

// File: rtl/pht_update_scheduler_if.sv
// Branch-result request lanes in, PHT write port and status out.
interface pht_update_scheduler_if
    import pht_update_scheduler_pkg::*;
#(
    parameter int REQ_NUM     = 2,
    parameter int INDEX_WIDTH = 10
);
    logic [REQ_NUM-1:0]                  req_valid;
    logic [REQ_NUM-1:0][INDEX_WIDTH-1:0] req_index;
    PHT_CounterPath [REQ_NUM-1:0]        req_prev;
    logic [REQ_NUM-1:0]                  req_taken;

    logic                   pht_we;
    logic [INDEX_WIDTH-1:0] pht_wa;
    PHT_CounterPath         pht_wv;
    logic                   init_busy;
    logic                   almost_full;
    logic [15:0]            drop_count;

    modport master (
        output req_valid, req_index, req_prev, req_taken,
        input  pht_we, pht_wa, pht_wv, init_busy, almost_full, drop_count
    );

    modport slave (
        input  req_valid, req_index, req_prev, req_taken,
        output pht_we, pht_wa, pht_wv, init_busy, almost_full, drop_count
    );
endinterface

// File: rtl/pht_update_fifo.sv
// Circular update buffer: LANES contiguous write lanes, one head read,
// and an in-place value rewrite of the youngest entry.
module pht_update_fifo
    import pht_update_scheduler_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int LANES       = 2,
    parameter int INDEX_WIDTH = 10,
    parameter int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [LANES-1:0]                    wr_en_i,
    input  logic [LANES-1:0][INDEX_WIDTH-1:0]   wr_index_i,
    input  PHT_CounterPath [LANES-1:0]          wr_value_i,
    input  logic                                rd_en_i,
    input  logic                                tail_we_i,
    input  PHT_CounterPath                      tail_value_i,
    output logic [INDEX_WIDTH-1:0]              head_index_o,
    output PHT_CounterPath                      head_value_o,
    output logic [INDEX_WIDTH-1:0]              tail_index_o,
    output PHT_CounterPath                      tail_value_o,
    output logic [CNT_W-1:0]                    count_o,
    output logic [CNT_W-1:0]                    count_next_o
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        PHT_CounterPath         value;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [PTR_W-1:0]  youngest;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  n_wr;

    always_comb begin
        n_wr = '0;
        for (int k = 0; k < LANES; k++) begin
            n_wr = n_wr + CNT_W'(wr_en_i[k]);
        end
    end

    assign youngest     = tail_q - PTR_W'(1);
    assign count_next_o = count_q + n_wr - CNT_W'(rd_en_i);
    assign count_o      = count_q;
    assign head_index_o = mem[head_q].index;
    assign head_value_o = mem[head_q].value;
    assign tail_index_o = mem[youngest].index;
    assign tail_value_o = mem[youngest].value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(rd_en_i);
            tail_q  <= tail_q + PTR_W'(n_wr);
            count_q <= count_next_o;
        end
    end

    // NOTE: storage has no reset; the pointers and occupancy alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (tail_we_i) begin
            mem[youngest].value <= tail_value_i;
        end
        for (int k = 0; k < LANES; k++) begin
            if (wr_en_i[k]) begin
                mem[tail_q + PTR_W'(k)] <= '{index: wr_index_i[k], value: wr_value_i[k]};
            end
        end
    end

endmodule

// File: rtl/pht_update_scheduler.sv
// Owns the PHT write port: a weakly-taken sweep after reset, then merged
// branch-result updates drained one write per cycle.
module pht_update_scheduler
    import pht_update_scheduler_pkg::*;
#(
    parameter int ENTRY_NUM   = 1024,
    parameter int INDEX_WIDTH = 10,
    parameter int REQ_NUM     = 2,
    parameter int QUEUE_DEPTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    pht_update_scheduler_if.slave bus
);
    localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;
    localparam int LIDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int LCNT_W = $clog2(REQ_NUM + 1);

    SchedState              state_q;
    logic [INDEX_WIDTH-1:0] init_idx_q;
    logic                   pht_we_q;
    logic [INDEX_WIDTH-1:0] pht_wa_q;
    PHT_CounterPath         pht_wv_q;
    logic                   init_busy_q;
    logic                   almost_full_q;
    logic [15:0]            drop_count_q;
    logic [15:0]            drop_count_d;
    logic [16:0]            drop_sum;

    logic [REQ_NUM-1:0]                  wr_en;
    logic [REQ_NUM-1:0][INDEX_WIDTH-1:0] wr_index;
    PHT_CounterPath [REQ_NUM-1:0]        wr_value;
    logic                   tail_we;
    PHT_CounterPath         tail_value;
    logic [INDEX_WIDTH-1:0] head_index;
    PHT_CounterPath         head_value;
    logic [INDEX_WIDTH-1:0] tail_index;
    PHT_CounterPath         tail_stored;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;
    logic [CNT_W-1:0]       free_slots;
    logic                   deq;
    logic                   tail_mergeable;
    logic [LCNT_W-1:0]      n_alloc;
    logic [LCNT_W-1:0]      n_drop;

    assign deq        = (state_q == RUN) && (count != '0);
    assign free_slots = CNT_W'(QUEUE_DEPTH) - count + CNT_W'(deq);
    // The youngest entry cannot absorb an update while it is also the head leaving this cycle.
    assign tail_mergeable = (count != '0) && !((count == CNT_W'(1)) && deq);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        PHT_CounterPath    src;
        logic              matched;
        PHT_CounterPath    new_val [REQ_NUM];
        logic [LIDX_W-1:0] lane_of [REQ_NUM];
        logic              hit_tail [REQ_NUM];
        logic              lands [REQ_NUM];

        wr_en      = '0;
        wr_index   = '0;
        wr_value   = '0;
        tail_we    = 1'b0;
        tail_value = tail_stored;
        n_alloc    = '0;
        n_drop     = '0;
        src        = '0;
        matched    = 1'b0;
        for (int j = 0; j < REQ_NUM; j++) begin
            new_val[j]  = bus.req_prev[j];
            lane_of[j]  = '0;
            hit_tail[j] = 1'b0;
            lands[j]    = 1'b0;
        end

        // NOTE: blocking assignments are deliberate; later ports read the values earlier ports produced in this pass.
        for (int j = 0; j < REQ_NUM; j++) begin
            src     = bus.req_prev[j];
            matched = 1'b0;
            if (bus.req_valid[j] && (state_q != RUN)) begin
                n_drop = n_drop + 1'b1;
            end else if (bus.req_valid[j]) begin
                for (int i = 0; i < j; i++) begin
                    if (bus.req_valid[i] && (bus.req_index[i] == bus.req_index[j])) begin
                        matched     = 1'b1;
                        src         = new_val[i];
                        lane_of[j]  = lane_of[i];
                        hit_tail[j] = hit_tail[i];
                        lands[j]    = lands[i];
                    end
                end
                if (!matched && tail_mergeable && (tail_index == bus.req_index[j])) begin
                    hit_tail[j] = 1'b1;
                    lands[j]    = 1'b1;
                    src         = tail_stored;
                end else if (!matched) begin
                    lane_of[j] = LIDX_W'(n_alloc);
                    lands[j]   = CNT_W'(n_alloc) < free_slots;
                    n_alloc    = n_alloc + 1'b1;
                end
                new_val[j] = ctr_next(src, bus.req_taken[j]);

                if (!lands[j]) begin
                    n_drop = n_drop + 1'b1;
                end else if (hit_tail[j]) begin
                    tail_we    = 1'b1;
                    tail_value = new_val[j];
                end else begin
                    wr_en[lane_of[j]]    = 1'b1;
                    wr_index[lane_of[j]] = bus.req_index[j];
                    wr_value[lane_of[j]] = new_val[j];
                end
            end
        end
    end

    assign drop_sum     = {1'b0, drop_count_q} + 17'(n_drop);
    assign drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    pht_update_fifo #(
        .DEPTH       (QUEUE_DEPTH),
        .LANES       (REQ_NUM),
        .INDEX_WIDTH (INDEX_WIDTH),
        .CNT_W       (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (wr_en),
        .wr_index_i   (wr_index),
        .wr_value_i   (wr_value),
        .rd_en_i      (deq),
        .tail_we_i    (tail_we),
        .tail_value_i (tail_value),
        .head_index_o (head_index),
        .head_value_o (head_value),
        .tail_index_o (tail_index),
        .tail_value_o (tail_stored),
        .count_o      (count),
        .count_next_o (count_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= INIT;
            init_idx_q    <= '0;
            pht_we_q      <= 1'b0;
            pht_wa_q      <= '0;
            pht_wv_q      <= '0;
            init_busy_q   <= 1'b1;
            almost_full_q <= 1'b0;
            drop_count_q  <= '0;
        end else begin
            drop_count_q  <= drop_count_d;
            almost_full_q <= count_next >= CNT_W'(QUEUE_DEPTH - REQ_NUM);
            case (state_q)
                INIT: begin
                    pht_we_q    <= 1'b1;
                    pht_wa_q    <= init_idx_q;
                    pht_wv_q    <= CTR_INIT;
                    init_busy_q <= 1'b1;
                    init_idx_q  <= init_idx_q + 1'b1;
                    if (init_idx_q == INDEX_WIDTH'(ENTRY_NUM - 1)) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    init_busy_q <= 1'b0;
                    pht_we_q    <= deq;
                    if (deq) begin
                        pht_wa_q <= head_index;
                        pht_wv_q <= head_value;
                    end
                end
            endcase
        end
    end

    assign bus.pht_we      = pht_we_q;
    assign bus.pht_wa      = pht_wa_q;
    assign bus.pht_wv      = pht_wv_q;
    assign bus.init_busy   = init_busy_q;
    assign bus.almost_full = almost_full_q;
    assign bus.drop_count  = drop_count_q;

endmodule
